// File: rtl/fetch_stage.sv
// Instruction fetch stage with PC, imem handshake, one-entry hold buffer and IF/ID register.
// Zero-wait memory: a request in cycle N lands in IF/ID at the closing edge; a stalled fetch parks in the hold buffer.
module fetch_stage #(
   parameter int                 PC_W     = 16,
   parameter int                 INSTR_W  = 16,
   parameter logic [PC_W-1:0]    RESET_PC = '0,
   parameter logic [INSTR_W-1:0] NOP      = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall_f,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_ready,
   output logic [INSTR_W-1:0] instr_d,
   output logic [PC_W-1:0]    pc_d,
   output logic [PC_W-1:0]    pc_plus1_d,
   output logic               valid_d,
   output logic               fetch_busy
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DISCARD} state_t;

   state_t             r_state, w_state_nxt;
   logic [PC_W-1:0]    r_pc_f, w_pc_f_nxt;
   logic [PC_W-1:0]    r_pend_pc, w_pend_pc_nxt;
   logic               r_hold_vld, w_hold_vld_nxt;
   logic [INSTR_W-1:0] r_hold_instr, w_hold_instr_nxt;
   logic [PC_W-1:0]    r_hold_pc, w_hold_pc_nxt;
   logic [INSTR_W-1:0] r_instr_d, w_instr_d_nxt;
   logic [PC_W-1:0]    r_pc_d, w_pc_d_nxt;
   logic [PC_W-1:0]    r_pc_plus1_d, w_pc_plus1_d_nxt;
   logic               r_valid_d, w_valid_d_nxt;

   logic               w_req;
   logic               w_acc;
   logic [PC_W-1:0]    w_pc_inc;
   logic [PC_W-1:0]    w_hold_inc;

   // No request while a word is parked, so the held word never gets overwritten.
   assign w_req      = ((r_state == S_FETCH) & ~r_hold_vld) | (r_state == S_DISCARD);
   assign w_acc      = w_req & imem_ready;
   assign w_pc_inc   = r_pc_f + PC_W'(1);
   assign w_hold_inc = r_hold_pc + PC_W'(1);

   assign imem_req   = w_req;
   assign imem_addr  = r_pc_f;
   assign fetch_busy = w_req & ~imem_ready;
   assign instr_d    = r_instr_d;
   assign pc_d       = r_pc_d;
   assign pc_plus1_d = r_pc_plus1_d;
   assign valid_d    = r_valid_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_pc_f_nxt       = r_pc_f;
      w_pend_pc_nxt    = r_pend_pc;
      w_hold_vld_nxt   = r_hold_vld;
      w_hold_instr_nxt = r_hold_instr;
      w_hold_pc_nxt    = r_hold_pc;
      w_instr_d_nxt    = r_instr_d;
      w_pc_d_nxt       = r_pc_d;
      w_pc_plus1_d_nxt = r_pc_plus1_d;
      w_valid_d_nxt    = r_valid_d;
      case (r_state)
         S_IDLE: begin
            w_state_nxt   = S_FETCH;
            w_instr_d_nxt = NOP;
            w_valid_d_nxt = 1'b0;
         end
         S_FETCH: begin
            if (redirect) begin
               w_hold_vld_nxt = 1'b0;
               w_instr_d_nxt  = NOP;
               w_valid_d_nxt  = 1'b0;
               // An access still in flight must finish at its old address first.
               if (w_acc | ~w_req) begin
                  w_pc_f_nxt = redirect_pc;
               end else begin
                  w_pend_pc_nxt = redirect_pc;
                  w_state_nxt   = S_DISCARD;
               end
            end else if (stall_f) begin
               if (w_acc) begin
                  w_hold_vld_nxt   = 1'b1;
                  w_hold_instr_nxt = imem_rdata;
                  w_hold_pc_nxt    = r_pc_f;
                  w_pc_f_nxt       = w_pc_inc;
               end
            end else if (r_hold_vld) begin
               w_hold_vld_nxt   = 1'b0;
               w_instr_d_nxt    = r_hold_instr;
               w_pc_d_nxt       = r_hold_pc;
               w_pc_plus1_d_nxt = w_hold_inc;
               w_valid_d_nxt    = 1'b1;
            end else if (w_acc) begin
               w_instr_d_nxt    = imem_rdata;
               w_pc_d_nxt       = r_pc_f;
               w_pc_plus1_d_nxt = w_pc_inc;
               w_valid_d_nxt    = 1'b1;
               w_pc_f_nxt       = w_pc_inc;
            end else begin
               w_instr_d_nxt = NOP;
               w_valid_d_nxt = 1'b0;
            end
         end
         S_DISCARD: begin
            w_instr_d_nxt = NOP;
            w_valid_d_nxt = 1'b0;
            if (redirect) w_pend_pc_nxt = redirect_pc;
            if (imem_ready) begin
               w_pc_f_nxt  = redirect ? redirect_pc : r_pend_pc;
               w_state_nxt = S_FETCH;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc_f       <= RESET_PC;
         r_pend_pc    <= '0;
         r_hold_vld   <= 1'b0;
         r_hold_instr <= '0;
         r_hold_pc    <= '0;
         r_instr_d    <= NOP;
         r_pc_d       <= '0;
         r_pc_plus1_d <= '0;
         r_valid_d    <= 1'b0;
      end else begin
         r_pc_f       <= w_pc_f_nxt;
         r_pend_pc    <= w_pend_pc_nxt;
         r_hold_vld   <= w_hold_vld_nxt;
         r_hold_instr <= w_hold_instr_nxt;
         r_hold_pc    <= w_hold_pc_nxt;
         r_instr_d    <= w_instr_d_nxt;
         r_pc_d       <= w_pc_d_nxt;
         r_pc_plus1_d <= w_pc_plus1_d_nxt;
         r_valid_d    <= w_valid_d_nxt;
      end
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 16-bit, 8-register pipelined core. It owns the PC and drives the instruction-memory request/ready handshake. It consumes the fetch `Stall` from the hazard unit and the taken-branch redirect from decode/execute. It presents a stable, valid-tagged instruction to decode, using a one-entry hold buffer so that no fetched word is lost while decode is stalled.

## Interface
- `PC_W`, 16: PC and instruction-memory address width (word addressed).
- `INSTR_W`, 16: instruction width.
- `RESET_PC`, 0: PC value loaded on reset.
- `NOP`, 16'h0000: encoding driven on `instr_d` for bubbles.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall_f`  in  1  hazard-unit Stall; hold PC-to-decode progress.
- `redirect`  in  1  taken branch/jump resolved this cycle.
- `redirect_pc`  in  PC_W  target for `redirect`.
- `imem_req`  out  1  request to instruction memory.
- `imem_addr`  out  PC_W  request address.
- `imem_rdata`  in  INSTR_W  read data, valid when `imem_ready`.
- `imem_ready`  in  1  access completes this cycle.
- `instr_d`  out  INSTR_W  IF/ID instruction.
- `pc_d`  out  PC_W  PC of `instr_d`.
- `pc_plus1_d`  out  PC_W  `pc_d`+1 (mod 2^PC_W), used for link/branch base.
- `valid_d`  out  1  `instr_d` is a real instruction, not a bubble.
- `fetch_busy`  out  1  `imem_req & ~imem_ready`.

## Operation
- State: `pc_f`, FSM {IDLE, FETCH, DISCARD}, `pend_pc`, hold buffer {`hold_valid`, `hold_instr`, `hold_pc`}, IF/ID register.
- `imem_addr` = `pc_f` at all times.
- `imem_req` = (state==FETCH & ~hold_valid) | state==DISCARD.
- Memory rule: once `imem_req`=1, `imem_addr` stays stable until the cycle with `imem_ready`=1.
- IDLE: entered only by reset. `imem_req`=0. Moves to FETCH on the next edge unconditionally.
- FETCH, priority redirect > stall > advance:
  - `redirect` and (`imem_ready` or no request outstanding): `pc_f`←`redirect_pc`; clear hold; IF/ID←bubble; stay FETCH.
  - `redirect` with request outstanding and `~imem_ready`: `pend_pc`←`redirect_pc`; clear hold; IF/ID←bubble; go DISCARD.
  - `stall_f`: IF/ID holds. If `imem_ready`, capture {`imem_rdata`, `pc_f`} into hold, set `hold_valid`, and `pc_f`←`pc_f`+1.
  - Otherwise:
    - If `hold_valid`: IF/ID←hold; clear `hold_valid`.
    - Else if `imem_ready`: IF/ID←{`imem_rdata`, `pc_f`, `pc_f`+1, valid=1} and `pc_f`←`pc_f`+1.
    - Else: IF/ID←bubble.
- DISCARD: `imem_req` stays 1 at the old `pc_f`; IF/ID forced to bubble regardless of `stall_f`.
  - A new `redirect` overwrites `pend_pc`.
  - On `imem_ready`: data dropped; `pc_f`←`pend_pc` (or `redirect_pc` if `redirect` is asserted that same cycle); go FETCH.
- Bubble: `instr_d`=NOP, `valid_d`=0; `pc_d` and `pc_plus1_d` are held at their previous values.
- Arithmetic: `pc_f`+1 wraps from 2^PC_W−1 to 0.

## Timing
- Reset values (asynchronous, asserted immediately):
  - `pc_f`=RESET_PC, `imem_addr`=RESET_PC, `imem_req`=0.
  - `instr_d`=NOP, `pc_d`=0, `pc_plus1_d`=0, `valid_d`=0.
  - `hold_valid`=0, `fetch_busy`=0, state IDLE.
- Reset released mid-access: no in-flight state is kept; memory must tolerate request withdrawal on reset.
- Latency with zero-wait memory: the request made in cycle N appears on IF/ID after the edge ending cycle N. First instruction after reset is valid at edge 2.
- Throughput with zero-wait memory and no stalls: 1 instruction per cycle.
- Redirect penalty: the IF/ID bubble appears the edge after `redirect`. The target instruction is valid one edge later if memory is zero-wait; otherwise after the DISCARD completes plus the target access.
- Stall release: a held word enters IF/ID on the first unstalled edge. The next request issues in the same cycle as that first unstalled edge.
- `stall_f` and `imem_ready` together with `hold_valid`=1 cannot occur, because no request is outstanding while `hold_valid`=1.

## Test plan
- Zero-wait memory returning `imem_rdata`=addr+16'h1000, reset released: `valid_d` rises at edge 2 with `instr_d`=16'h1000 and `pc_d`=0, then `pc_d`=1, 2, 3 on consecutive edges.
- `stall_f` held for 3 cycles at `pc_f`=5 with zero-wait memory:
  - IF/ID frozen on the instruction at PC 4.
  - Hold buffer holds PC 5 and `imem_req`=0 for the remaining stall cycles.
  - On release: PC 5, then 6, with no gap and no duplicate.
- `redirect`=1, `redirect_pc`=16'h0040 with zero-wait memory: the next edge shows `valid_d`=0 and `instr_d`=NOP; the following edge shows `pc_d`=16'h0040.
- Memory with 3-cycle wait, `redirect` to 16'h0020 in the first wait cycle:
  - `imem_addr` stays at the old PC until `imem_ready`; returned data is discarded.
  - `imem_addr` then becomes 16'h0020; `valid_d` stays 0 throughout.
- `pc_f`=16'hFFFF, no stall: IF/ID shows `pc_d`=16'hFFFF and `pc_plus1_d`=16'h0000, and the next fetch address is 0.
- `rst_n` asserted while `hold_valid`=1 and a request is pending: all outputs take their reset values immediately, without waiting for a clock edge.
